// File: rtl/nx_instr_pkg.sv
// Shared types and sizing helpers for the instruction-RAM arbiter and its
// round-robin sub-block.
package nx_instr_pkg;

    localparam int DEF_INSTR_WIDTH = 15;
    localparam int DEF_MAX_INSTRS  = 512;

    function automatic int addr_w_f(input int max_instrs);
        return $clog2(max_instrs);
    endfunction

    localparam int DEF_ADDR_W = addr_w_f(DEF_MAX_INSTRS);

    typedef logic core_id_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_C0,
        GNT_C1,
        GNT_WR
    } grant_e;

endpackage

// File: rtl/nx_instr_arbiter_if.sv
// Bundle of load-path, core-fetch and RAM-macro signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding node.
interface nx_instr_arbiter_if
    import nx_instr_pkg::*;
#(
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int ADDR_W      = DEF_ADDR_W
);

    logic                   store_core_i;
    logic [INSTR_WIDTH-1:0] store_data_i;
    logic                   store_valid_i;
    logic                   overflow_o;

    logic [ADDR_W:0]        core_0_populated_o;
    logic [ADDR_W-1:0]      core_0_addr_i;
    logic                   core_0_rd_i;
    logic                   core_0_stall_o;
    logic [INSTR_WIDTH-1:0] core_0_data_o;
    logic                   core_0_valid_o;

    logic [ADDR_W:0]        core_1_populated_o;
    logic [ADDR_W-1:0]      core_1_addr_i;
    logic                   core_1_rd_i;
    logic                   core_1_stall_o;
    logic [INSTR_WIDTH-1:0] core_1_data_o;
    logic                   core_1_valid_o;

    logic [ADDR_W:0]        ram_addr_o;
    logic                   ram_wr_en_o;
    logic [INSTR_WIDTH-1:0] ram_wr_data_o;
    logic                   ram_rd_en_o;
    logic [INSTR_WIDTH-1:0] ram_rd_data_i;

    modport slave (
        input  store_core_i, store_data_i, store_valid_i,
        output overflow_o,
        output core_0_populated_o, core_0_stall_o, core_0_data_o, core_0_valid_o,
        input  core_0_addr_i, core_0_rd_i,
        output core_1_populated_o, core_1_stall_o, core_1_data_o, core_1_valid_o,
        input  core_1_addr_i, core_1_rd_i,
        output ram_addr_o, ram_wr_en_o, ram_wr_data_o, ram_rd_en_o,
        input  ram_rd_data_i
    );

    modport master (
        output store_core_i, store_data_i, store_valid_i,
        input  overflow_o,
        input  core_0_populated_o, core_0_stall_o, core_0_data_o, core_0_valid_o,
        output core_0_addr_i, core_0_rd_i,
        input  core_1_populated_o, core_1_stall_o, core_1_data_o, core_1_valid_o,
        output core_1_addr_i, core_1_rd_i,
        input  ram_addr_o, ram_wr_en_o, ram_wr_data_o, ram_rd_en_o,
        output ram_rd_data_i
    );

endinterface

// File: rtl/nx_rr_arbiter2.sv
// Two-requester round-robin arbiter: on a tie the requester that did not win
// most recently is granted. Grant is combinational, pointer is registered.
module nx_rr_arbiter2
    import nx_instr_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    core_id_t ptr_q;
    core_id_t ptr_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = ptr_q ? 2'b01 : 2'b10;
        end
        ptr_d = ptr_q;
        if (gnt_o[1]) begin
            ptr_d = 1'b1;
        end else if (gnt_o[0]) begin
            ptr_d = 1'b0;
        end
    end

    // Pointer starts at requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/nx_instr_arbiter.sv
// Single-port instruction RAM sequencer: load-path appends have priority,
// core fetches are round-robin arbitrated, each core owns half of the RAM.
module nx_instr_arbiter
    import nx_instr_pkg::*;
#(
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int MAX_INSTRS  = DEF_MAX_INSTRS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    nx_instr_arbiter_if.slave bus
);

    localparam int              ADDR_W = addr_w_f(MAX_INSTRS);
    localparam logic [ADDR_W:0] FULL   = (ADDR_W + 1)'(MAX_INSTRS);
    localparam logic [ADDR_W:0] ONE    = (ADDR_W + 1)'(1);

    logic [1:0][ADDR_W:0]        populated_q;
    logic [1:0][ADDR_W:0]        populated_d;
    logic                        overflow_q;
    logic                        overflow_d;
    logic [1:0]                  pend_q;
    logic [1:0]                  pend_d;
    logic [1:0]                  oor_q;
    logic [1:0]                  oor_d;
    logic [1:0][INSTR_WIDTH-1:0] data_q;
    logic [1:0][INSTR_WIDTH-1:0] data_d;

    logic [1:0][ADDR_W-1:0] rd_addr;
    logic [1:0]             rd_req;
    logic [1:0]             in_range;
    logic [1:0]             elig;
    logic [1:0]             oor_req;
    logic [1:0]             arb_req;
    logic [1:0]             arb_gnt;
    logic [1:0]             stall;
    logic [1:0]             done_en;
    logic [1:0]             valid;
    core_id_t               wr_core;
    logic                   wr_full;
    logic                   wr_fire;
    grant_e                 gnt;
    logic [ADDR_W:0]        ram_addr;
    logic                   ram_wr_en;
    logic                   ram_rd_en;

    // Eligibility uses the post-write count so a fetch of the slot being
    // appended this cycle stalls behind the write instead of reading as empty.
    always_comb begin
        rd_req      = {bus.core_1_rd_i, bus.core_0_rd_i};
        rd_addr[0]  = bus.core_0_addr_i;
        rd_addr[1]  = bus.core_1_addr_i;
        wr_core     = bus.store_core_i;
        wr_full     = (populated_q[wr_core] == FULL);
        wr_fire     = bus.store_valid_i & ~wr_full;
        populated_d = populated_q;
        if (wr_fire) begin
            populated_d[wr_core] = populated_q[wr_core] + ONE;
        end
        overflow_d = overflow_q | (bus.store_valid_i & wr_full);
        for (int n = 0; n < 2; n++) begin
            in_range[n] = ({1'b0, rd_addr[n]} < populated_d[n]);
            elig[n]     = rd_req[n] & in_range[n];
            oor_req[n]  = rd_req[n] & ~in_range[n];
        end
        arb_req = wr_fire ? 2'b00 : elig;
    end

    nx_rr_arbiter2 u_rr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (arb_req),
        .gnt_o (arb_gnt)
    );

    always_comb begin
        gnt = GNT_NONE;
        if (wr_fire) begin
            gnt = GNT_WR;
        end else if (arb_gnt[0]) begin
            gnt = GNT_C0;
        end else if (arb_gnt[1]) begin
            gnt = GNT_C1;
        end
        ram_addr  = '0;
        ram_wr_en = 1'b0;
        ram_rd_en = 1'b0;
        case (gnt)
            GNT_WR: begin
                ram_wr_en = 1'b1;
                ram_addr  = {wr_core, populated_q[wr_core][ADDR_W-1:0]};
            end
            GNT_C0: begin
                ram_rd_en = 1'b1;
                ram_addr  = {1'b0, rd_addr[0]};
            end
            GNT_C1: begin
                ram_rd_en = 1'b1;
                ram_addr  = {1'b1, rd_addr[1]};
            end
            default: begin
            end
        endcase
        stall = elig & ~arb_gnt;
    end

    // RAM data for a fetch granted just before reset is dropped while rst_i is high.
    always_comb begin
        done_en = ~{2{rst_i}};
        pend_d  = arb_gnt;
        oor_d   = oor_req;
        for (int n = 0; n < 2; n++) begin
            if (pend_q[n] & done_en[n]) begin
                data_d[n] = bus.ram_rd_data_i;
            end else if (oor_q[n] & done_en[n]) begin
                data_d[n] = '0;
            end else begin
                data_d[n] = data_q[n];
            end
        end
        valid = (pend_q | oor_q) & done_en;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            populated_q <= '0;
            overflow_q  <= 1'b0;
            pend_q      <= '0;
            oor_q       <= '0;
            data_q      <= '0;
        end else begin
            populated_q <= populated_d;
            overflow_q  <= overflow_d;
            pend_q      <= pend_d;
            oor_q       <= oor_d;
            data_q      <= data_d;
        end
    end

    assign bus.overflow_o         = overflow_q;
    assign bus.core_0_populated_o = populated_q[0];
    assign bus.core_1_populated_o = populated_q[1];
    assign bus.core_0_stall_o     = stall[0];
    assign bus.core_1_stall_o     = stall[1];
    assign bus.core_0_data_o      = data_d[0];
    assign bus.core_1_data_o      = data_d[1];
    assign bus.core_0_valid_o     = valid[0];
    assign bus.core_1_valid_o     = valid[1];
    assign bus.ram_addr_o         = ram_addr;
    assign bus.ram_wr_en_o        = ram_wr_en;
    assign bus.ram_wr_data_o      = bus.store_data_i;
    assign bus.ram_rd_en_o        = ram_rd_en;

endmodule

// File: tb/tb_nx_instr_arbiter.sv
// Bench for nx_instr_arbiter: scenario tasks plus a cycle monitor that keeps a
// reference model and a per-core queue of expected fetch results.
module tb_nx_instr_arbiter;

    localparam int W  = 15;
    localparam int AW = 9;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    nx_instr_arbiter_if #(.INSTR_WIDTH(W), .ADDR_W(AW)) bus ();

    nx_instr_arbiter #(.INSTR_WIDTH(W), .MAX_INSTRS(512)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural RAM macro: one-cycle read latency.
    logic [W-1:0] ram [0:1023];
    always @(posedge clk) begin
        if (bus.ram_wr_en_o) ram[bus.ram_addr_o] <= bus.ram_wr_data_o;
        if (bus.ram_rd_en_o) bus.ram_rd_data_i <= ram[bus.ram_addr_o];
    end

    function automatic logic [W-1:0] word_f(input int c, input int s);
        return W'((c * 16384) + (s * 37) + 5);
    endfunction

    // Reference model state and scoreboard.
    logic [W-1:0] m_mem [0:1023];
    logic [9:0]   m_pop [2];
    bit           m_ptr = 1'b1;
    bit           m_ovf = 1'b0;
    logic [W-1:0] last0 = '0;
    logic [W-1:0] last1 = '0;
    logic [W-1:0] q0 [$];
    logic [W-1:0] q1 [$];

    initial begin
        m_pop[0] = '0;
        m_pop[1] = '0;
    end

    always @(negedge clk) begin
        logic [W-1:0] exp_w;
        logic         wr;
        logic [9:0]   pop_n [2];
        logic [1:0]   rq, el, oo, g;
        logic [8:0]   a [2];
        logic         c;
        if (rst) begin
            n_cmp++;
            if (bus.core_0_valid_o !== 1'b0 || bus.core_1_valid_o !== 1'b0) begin
                n_bad++;
                $display("FAIL mon_rst_valid t=%0t got %b%b want 00", $time,
                         bus.core_1_valid_o, bus.core_0_valid_o);
            end
            m_pop[0] = '0; m_pop[1] = '0; m_ptr = 1'b1; m_ovf = 1'b0;
            last0 = '0; last1 = '0;
            q0.delete(); q1.delete();
        end else begin
            n_cmp++;
            if (q0.size() != 0) begin
                exp_w = q0.pop_front();
                if (bus.core_0_valid_o !== 1'b1 || bus.core_0_data_o !== exp_w) begin
                    n_bad++;
                    $display("FAIL mon_c0_done t=%0t got vld=%b data=%h want vld=1 data=%h",
                             $time, bus.core_0_valid_o, bus.core_0_data_o, exp_w);
                end
                last0 = exp_w;
            end else if (bus.core_0_valid_o !== 1'b0 || bus.core_0_data_o !== last0) begin
                n_bad++;
                $display("FAIL mon_c0_idle t=%0t got vld=%b data=%h want vld=0 data=%h",
                         $time, bus.core_0_valid_o, bus.core_0_data_o, last0);
            end
            n_cmp++;
            if (q1.size() != 0) begin
                exp_w = q1.pop_front();
                if (bus.core_1_valid_o !== 1'b1 || bus.core_1_data_o !== exp_w) begin
                    n_bad++;
                    $display("FAIL mon_c1_done t=%0t got vld=%b data=%h want vld=1 data=%h",
                             $time, bus.core_1_valid_o, bus.core_1_data_o, exp_w);
                end
                last1 = exp_w;
            end else if (bus.core_1_valid_o !== 1'b0 || bus.core_1_data_o !== last1) begin
                n_bad++;
                $display("FAIL mon_c1_idle t=%0t got vld=%b data=%h want vld=0 data=%h",
                         $time, bus.core_1_valid_o, bus.core_1_data_o, last1);
            end
            n_cmp++;
            if (bus.core_0_populated_o !== m_pop[0] || bus.core_1_populated_o !== m_pop[1]
                || bus.overflow_o !== m_ovf) begin
                n_bad++;
                $display("FAIL mon_status t=%0t got pop=%0d/%0d ovf=%b want pop=%0d/%0d ovf=%b",
                         $time, bus.core_0_populated_o, bus.core_1_populated_o, bus.overflow_o,
                         m_pop[0], m_pop[1], m_ovf);
            end
            c  = bus.store_core_i;
            wr = bus.store_valid_i && (m_pop[c] < 10'd512);
            pop_n[0] = m_pop[0];
            pop_n[1] = m_pop[1];
            if (wr) pop_n[c] = m_pop[c] + 10'd1;
            rq   = {bus.core_1_rd_i, bus.core_0_rd_i};
            a[0] = bus.core_0_addr_i;
            a[1] = bus.core_1_addr_i;
            for (int n = 0; n < 2; n++) begin
                el[n] = rq[n] && ({1'b0, a[n]} < pop_n[n]);
                oo[n] = rq[n] && !({1'b0, a[n]} < pop_n[n]);
            end
            g = 2'b00;
            if (!wr) g = (el == 2'b11) ? (m_ptr ? 2'b01 : 2'b10) : el;
            n_cmp++;
            if ({bus.core_1_stall_o, bus.core_0_stall_o} !== (el & ~g)
                || bus.ram_wr_en_o !== wr || bus.ram_rd_en_o !== (g != 2'b00)) begin
                n_bad++;
                $display("FAIL mon_ctrl t=%0t got stall=%b wr=%b rd=%b want stall=%b wr=%b rd=%b",
                         $time, {bus.core_1_stall_o, bus.core_0_stall_o}, bus.ram_wr_en_o,
                         bus.ram_rd_en_o, el & ~g, wr, g != 2'b00);
            end
            if (wr) begin
                n_cmp++;
                if (bus.ram_addr_o !== {c, m_pop[c][8:0]} || bus.ram_wr_data_o !== bus.store_data_i) begin
                    n_bad++;
                    $display("FAIL mon_wr_addr t=%0t got %h want %h", $time, bus.ram_addr_o,
                             {c, m_pop[c][8:0]});
                end
                m_mem[{c, m_pop[c][8:0]}] = bus.store_data_i;
            end
            if (g != 2'b00) begin
                n_cmp++;
                if (bus.ram_addr_o !== {g[1], a[g[1]]}) begin
                    n_bad++;
                    $display("FAIL mon_rd_addr t=%0t got %h want %h", $time, bus.ram_addr_o,
                             {g[1], a[g[1]]});
                end
                m_ptr = g[1];
            end
            if (g[0]) q0.push_back(m_mem[{1'b0, a[0]}]);
            else if (oo[0]) q0.push_back('0);
            if (g[1]) q1.push_back(m_mem[{1'b1, a[1]}]);
            else if (oo[1]) q1.push_back('0);
            if (bus.store_valid_i && !wr) m_ovf = 1'b1;
            m_pop[0] = pop_n[0];
            m_pop[1] = pop_n[1];
        end
    end

    task automatic drive_idle();
        bus.store_valid_i = 1'b0;
        bus.store_core_i  = 1'b0;
        bus.store_data_i  = '0;
        bus.core_0_rd_i   = 1'b0;
        bus.core_0_addr_i = '0;
        bus.core_1_rd_i   = 1'b0;
        bus.core_1_addr_i = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        repeat (3) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.core_0_populated_o !== 10'd0 || bus.core_1_populated_o !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_pop got %0d/%0d want 0/0", bus.core_0_populated_o, bus.core_1_populated_o);
        end
        n_cmp++;
        if (bus.overflow_o !== 1'b0 || bus.core_0_valid_o !== 1'b0 || bus.core_1_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags got ovf=%b vld=%b%b want 0 00", bus.overflow_o,
                     bus.core_1_valid_o, bus.core_0_valid_o);
        end
        n_cmp++;
        if (bus.core_0_data_o !== '0 || bus.core_1_data_o !== '0) begin
            n_bad++;
            $display("FAIL reset_data got %h/%h want 0/0", bus.core_0_data_o, bus.core_1_data_o);
        end
    endtask

    task automatic test_load();
        for (int i = 0; i < 5; i++) begin
            int c;
            int s;
            c = (i < 3) ? 0 : 1;
            s = (i < 3) ? i : i - 3;
            next_cycle();
            bus.store_valid_i = 1'b1;
            bus.store_core_i  = c[0];
            bus.store_data_i  = word_f(c, s);
            @(negedge clk);
            n_cmp++;
            if (bus.ram_wr_en_o !== 1'b1 || bus.ram_addr_o !== 10'(c * 512 + s)) begin
                n_bad++;
                $display("FAIL load_wr got en=%b addr=%0d want en=1 addr=%0d", bus.ram_wr_en_o,
                         bus.ram_addr_o, c * 512 + s);
            end
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_cmp++;
        if (bus.core_0_populated_o !== 10'd3 || bus.core_1_populated_o !== 10'd2) begin
            n_bad++;
            $display("FAIL load_pop got %0d/%0d want 3/2", bus.core_0_populated_o, bus.core_1_populated_o);
        end
    endtask

    task automatic test_out_of_range();
        next_cycle();
        bus.core_1_rd_i   = 1'b1;
        bus.core_1_addr_i = 9'd1;
        @(negedge clk);
        n_cmp++;
        if (bus.core_1_stall_o !== 1'b0 || bus.ram_rd_en_o !== 1'b1 || bus.ram_addr_o !== 10'd513) begin
            n_bad++;
            $display("FAIL oor_inrange got stall=%b rd=%b addr=%0d want 0 1 513", bus.core_1_stall_o,
                     bus.ram_rd_en_o, bus.ram_addr_o);
        end
        next_cycle();
        bus.core_1_addr_i = 9'd5;
        @(negedge clk);
        n_cmp++;
        if (bus.core_1_stall_o !== 1'b0 || bus.ram_rd_en_o !== 1'b0) begin
            n_bad++;
            $display("FAIL oor_bypass got stall=%b rd=%b want 0 0", bus.core_1_stall_o, bus.ram_rd_en_o);
        end
        n_cmp++;
        if (bus.core_1_valid_o !== 1'b1 || bus.core_1_data_o !== word_f(1, 1)) begin
            n_bad++;
            $display("FAIL oor_prev_data got vld=%b data=%h want 1 %h", bus.core_1_valid_o,
                     bus.core_1_data_o, word_f(1, 1));
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_cmp++;
        if (bus.core_1_valid_o !== 1'b1 || bus.core_1_data_o !== '0) begin
            n_bad++;
            $display("FAIL oor_zero got vld=%b data=%h want 1 0", bus.core_1_valid_o, bus.core_1_data_o);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (bus.core_1_valid_o !== 1'b0 || bus.core_1_data_o !== '0) begin
            n_bad++;
            $display("FAIL oor_hold got vld=%b data=%h want 0 0", bus.core_1_valid_o, bus.core_1_data_o);
        end
    endtask

    task automatic test_write_priority();
        int rd_slot [2];
        rd_slot[0] = 1;
        rd_slot[1] = 4;
        // Second pass reads slot 4 while slot 4 itself is being appended.
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            bus.core_0_rd_i   = 1'b1;
            bus.core_0_addr_i = 9'(rd_slot[k]);
            bus.store_valid_i = 1'b1;
            bus.store_core_i  = 1'b0;
            bus.store_data_i  = word_f(0, 3 + k);
            @(negedge clk);
            n_cmp++;
            if (bus.core_0_stall_o !== 1'b1 || bus.ram_wr_en_o !== 1'b1 || bus.ram_addr_o !== 10'(3 + k)) begin
                n_bad++;
                $display("FAIL wrprio_stall got stall=%b wr=%b addr=%0d want 1 1 %0d", bus.core_0_stall_o,
                         bus.ram_wr_en_o, bus.ram_addr_o, 3 + k);
            end
            next_cycle();
            bus.store_valid_i = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (bus.core_0_stall_o !== 1'b0 || bus.ram_rd_en_o !== 1'b1 || bus.ram_addr_o !== 10'(rd_slot[k])) begin
                n_bad++;
                $display("FAIL wrprio_grant got stall=%b rd=%b addr=%0d want 0 1 %0d", bus.core_0_stall_o,
                         bus.ram_rd_en_o, bus.ram_addr_o, rd_slot[k]);
            end
            next_cycle();
            drive_idle();
            @(negedge clk);
            n_cmp++;
            if (bus.core_0_valid_o !== 1'b1 || bus.core_0_data_o !== word_f(0, rd_slot[k])) begin
                n_bad++;
                $display("FAIL wrprio_data got vld=%b data=%h want 1 %h", bus.core_0_valid_o,
                         bus.core_0_data_o, word_f(0, rd_slot[k]));
            end
        end
    endtask

    task automatic test_back_to_back();
        int turn;
        int a0;
        int a1;
        int st0;
        int st1;
        // Core 0 was granted last, so the first tie goes to core 1.
        turn = 1;
        a0 = 0; a1 = 0; st0 = 0; st1 = 0;
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            bus.core_0_rd_i   = 1'b1;
            bus.core_1_rd_i   = 1'b1;
            bus.core_0_addr_i = 9'(a0);
            bus.core_1_addr_i = 9'(a1);
            @(negedge clk);
            n_cmp++;
            if (bus.core_0_stall_o !== (turn != 0) || bus.core_1_stall_o !== (turn != 1)) begin
                n_bad++;
                $display("FAIL rr_turn cycle %0d got stall=%b%b want winner core %0d", i,
                         bus.core_1_stall_o, bus.core_0_stall_o, turn);
            end
            if (bus.core_0_stall_o === 1'b1) st0++;
            else a0 = (a0 + 1) % 5;
            if (bus.core_1_stall_o === 1'b1) st1++;
            else a1 = (a1 + 1) % 2;
            turn = 1 - turn;
        end
        n_cmp++;
        if (st0 != 6 || st1 != 6) begin
            n_bad++;
            $display("FAIL rr_share got stalls %0d/%0d want 6/6", st0, st1);
        end
        bus.core_1_rd_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            bus.core_0_addr_i = 9'(i);
            @(negedge clk);
            n_cmp++;
            if (bus.core_0_stall_o !== 1'b0 || bus.ram_rd_en_o !== 1'b1) begin
                n_bad++;
                $display("FAIL solo_stream cycle %0d got stall=%b rd=%b want 0 1", i,
                         bus.core_0_stall_o, bus.ram_rd_en_o);
            end
        end
        next_cycle();
        drive_idle();
    endtask

    task automatic test_overflow();
        for (int i = 2; i < 512; i++) begin
            next_cycle();
            bus.store_valid_i = 1'b1;
            bus.store_core_i  = 1'b1;
            bus.store_data_i  = word_f(1, i);
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_cmp++;
        if (bus.core_1_populated_o !== 10'd512 || bus.overflow_o !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_full got pop=%0d ovf=%b want 512 0", bus.core_1_populated_o, bus.overflow_o);
        end
        next_cycle();
        bus.store_valid_i = 1'b1;
        bus.store_core_i  = 1'b1;
        bus.store_data_i  = 15'h7abc;
        @(negedge clk);
        n_cmp++;
        if (bus.ram_wr_en_o !== 1'b0 || bus.ram_rd_en_o !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_drop got wr=%b rd=%b want 0 0", bus.ram_wr_en_o, bus.ram_rd_en_o);
        end
        next_cycle();
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.overflow_o !== 1'b1 || bus.core_1_populated_o !== 10'd512) begin
                n_bad++;
                $display("FAIL ovf_sticky cycle %0d got ovf=%b pop=%0d want 1 512", i,
                         bus.overflow_o, bus.core_1_populated_o);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_after_grant();
        bus.core_0_rd_i   = 1'b1;
        bus.core_0_addr_i = 9'd0;
        @(negedge clk);
        n_cmp++;
        if (bus.core_0_stall_o !== 1'b0 || bus.ram_rd_en_o !== 1'b1) begin
            n_bad++;
            $display("FAIL rstg_grant got stall=%b rd=%b want 0 1", bus.core_0_stall_o, bus.ram_rd_en_o);
        end
        next_cycle();
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.core_0_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL rstg_valid got %b want 0", bus.core_0_valid_o);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.core_0_populated_o !== 10'd0 || bus.core_1_populated_o !== 10'd0 || bus.overflow_o !== 1'b0
            || bus.core_0_valid_o !== 1'b0 || bus.core_0_data_o !== '0) begin
            n_bad++;
            $display("FAIL rstg_state got pop=%0d/%0d ovf=%b vld=%b data=%h want 0/0 0 0 0",
                     bus.core_0_populated_o, bus.core_1_populated_o, bus.overflow_o,
                     bus.core_0_valid_o, bus.core_0_data_o);
        end
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            bus.store_valid_i = 1'b1;
            bus.store_core_i  = c[0];
            bus.store_data_i  = word_f(c, 100);
        end
        next_cycle();
        drive_idle();
        bus.core_0_rd_i = 1'b1;
        bus.core_1_rd_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.core_0_stall_o !== 1'b0 || bus.core_1_stall_o !== 1'b1) begin
            n_bad++;
            $display("FAIL rstg_tie got stall=%b%b want 10", bus.core_1_stall_o, bus.core_0_stall_o);
        end
        next_cycle();
        bus.core_0_rd_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.core_1_stall_o !== 1'b0 || bus.core_0_data_o !== word_f(0, 100)) begin
            n_bad++;
            $display("FAIL rstg_c1_grant got stall=%b c0data=%h want 0 %h", bus.core_1_stall_o,
                     bus.core_0_data_o, word_f(0, 100));
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_cmp++;
        if (bus.core_1_valid_o !== 1'b1 || bus.core_1_data_o !== word_f(1, 100)) begin
            n_bad++;
            $display("FAIL rstg_c1_data got vld=%b data=%h want 1 %h", bus.core_1_valid_o,
                     bus.core_1_data_o, word_f(1, 100));
        end
        repeat (2) next_cycle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_load();
        test_out_of_range();
        test_write_priority();
        test_back_to_back();
        test_overflow();
        test_reset_after_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
